// File: rtl/mdu_hilo_pkg.sv
// Shared HILO micro-op encodings and result container for the mult/div unit.
// Imported by the decoder, the hazard unit and mdu_hilo.
package mdu_hilo_pkg;

  typedef enum logic [3:0] {
    HILO_NONE  = 4'd0,
    HILO_MULT  = 4'd1,
    HILO_MULTU = 4'd2,
    HILO_DIV   = 4'd3,
    HILO_DIVU  = 4'd4,
    HILO_MFLO  = 4'd5,
    HILO_MFHI  = 4'd6,
    HILO_MTLO  = 4'd7,
    HILO_MTHI  = 4'd8
  } hilo_type_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/mdu_hilo_if.sv
// E-stage request/response bundle between the pipeline and the HI/LO unit.
// The pipeline is the master; mdu_hilo is the slave.
interface mdu_hilo_if;

  logic [3:0]  HILO_type;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Start;
  logic        Busy;
  logic [31:0] HILO_out;

  modport master (
    output HILO_type, A, B, Req,
    input  Start, Busy, HILO_out
  );

  modport slave (
    input  HILO_type, A, B, Req,
    output Start, Busy, HILO_out
  );

endinterface

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers; results computed at issue, committed after a countdown.
// Start/Busy let the hazard unit stall later md/mf/mt ops; requests while Busy are ignored.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  mdu_hilo_if.slave   bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [31:0]      hi, lo;
  hilo_t            pend;
  logic             pend_wr;

  logic             is_mult, is_div, is_signed, start, div_zero;
  logic [63:0]      mul_a, mul_b, prod;
  logic [31:0]      dvs, quot, rem;
  hilo_t            result;

  assign busy = (cnt != '0);

  always_comb begin
    is_mult   = (bus.HILO_type == HILO_MULT) || (bus.HILO_type == HILO_MULTU);
    is_div    = (bus.HILO_type == HILO_DIV)  || (bus.HILO_type == HILO_DIVU);
    is_signed = (bus.HILO_type == HILO_MULT) || (bus.HILO_type == HILO_DIV);
    start     = (is_mult || is_div) && !busy && !bus.Req;
    div_zero  = is_div && (bus.B == 32'd0);
  end

  // Low 64 bits of the product of the extended operands equal the signed product.
  always_comb begin
    mul_a = is_signed ? {{32{bus.A[31]}}, bus.A} : {32'd0, bus.A};
    mul_b = is_signed ? {{32{bus.B[31]}}, bus.B} : {32'd0, bus.B};
    prod  = mul_a * mul_b;
  end

  // Divisor forced nonzero so a div-by-zero never produces X; its result is discarded.
  always_comb begin
    dvs  = (bus.B == 32'd0) ? 32'd1 : bus.B;
    quot = bus.A / dvs;
    rem  = bus.A % dvs;
    if (is_signed) begin
      if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
        quot = 32'h8000_0000;
        rem  = 32'd0;
      end else begin
        quot = $signed(bus.A) / $signed(dvs);
        rem  = $signed(bus.A) % $signed(dvs);
      end
    end
  end

  always_comb begin
    if (is_mult) begin
      result.hi = prod[63:32];
      result.lo = prod[31:0];
    end else begin
      result.hi = rem;
      result.lo = quot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1) && pend_wr) begin
        hi <= pend.hi;
        lo <= pend.lo;
      end
    end else if (start) begin
      cnt     <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      pend    <= result;
      pend_wr <= !div_zero;
    end else if (!bus.Req) begin
      if (bus.HILO_type == HILO_MTHI) hi <= bus.A;
      if (bus.HILO_type == HILO_MTLO) lo <= bus.A;
    end
  end

  assign bus.Start    = start;
  assign bus.Busy     = busy;
  assign bus.HILO_out = (bus.HILO_type == HILO_MFHI) ? hi :
                        (bus.HILO_type == HILO_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo: mult/div timing and results, mt/mf, Req, div-by-zero, reset abort.
module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.HILO_type = HILO_MFHI;
    #1;
    chk({tag, "_hi"}, bus.HILO_out, exp_hi);
    bus.HILO_type = HILO_MFLO;
    #1;
    chk({tag, "_lo"}, bus.HILO_out, exp_lo);
    bus.HILO_type = HILO_NONE;
    #1;
  endtask

  // Drive an md op for one edge; the unit must be idle when it is presented.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic req, input logic exp_start);
    chk({tag, "_idle"}, {31'd0, bus.Busy}, 32'd0);
    bus.HILO_type = op;
    bus.A         = a;
    bus.B         = b;
    bus.Req       = req;
    #1;
    chk({tag, "_start"}, {31'd0, bus.Start}, {31'd0, exp_start});
    tick();
    bus.HILO_type = HILO_NONE;
    bus.Req       = 1'b0;
  endtask

  // Called right after the issue edge: Busy must stay high for n cycles, then drop.
  task automatic run_busy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, bus.Busy}, 32'd1);
      tick();
    end
    chk({tag, "_done"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.HILO_type = HILO_NONE;
    bus.A         = 32'd0;
    bus.B         = 32'd0;
    bus.Req       = 1'b0;
    #12;
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_start", {31'd0, bus.Start}, 32'd0);
    chk("rst_out_none", bus.HILO_out, 32'd0);
    chk_hilo("rst", 32'd0, 32'd0);
    reset_n = 1'b1;
    tick();

    // mult -3 * 7
    issue("mult", HILO_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1);
    run_busy("mult", 5);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // divu 100 / 7 and signed div -7 / 2
    issue("divu", HILO_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
    run_busy("divu", 10);
    chk_hilo("divu", 32'd2, 32'd14);
    issue("div", HILO_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    run_busy("div", 10);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // signed overflow
    issue("ovf", HILO_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_busy("ovf", 10);
    chk_hilo("ovf", 32'd0, 32'h8000_0000);

    // mthi then mfhi next cycle; mtlo suppressed by Req
    bus.HILO_type = HILO_MTHI;
    bus.A         = 32'hDEAD_BEEF;
    tick();
    chk("mthi_nobusy", {31'd0, bus.Busy}, 32'd0);
    bus.HILO_type = HILO_MFHI;
    #1;
    chk("mfhi", bus.HILO_out, 32'hDEAD_BEEF);
    bus.HILO_type = HILO_MTLO;
    bus.A         = 32'h1234_5678;
    bus.Req       = 1'b1;
    tick();
    bus.Req       = 1'b0;
    chk_hilo("mtlo_req", 32'hDEAD_BEEF, 32'h8000_0000);

    // preload HI=1 LO=2, then divide by zero
    bus.HILO_type = HILO_MTHI;
    bus.A         = 32'd1;
    tick();
    bus.HILO_type = HILO_MTLO;
    bus.A         = 32'd2;
    tick();
    bus.HILO_type = HILO_NONE;
    chk_hilo("preload", 32'd1, 32'd2);
    issue("div0", HILO_DIV, 32'd55, 32'd0, 1'b0, 1'b1);
    run_busy("div0", 10);
    chk_hilo("div0", 32'd1, 32'd2);

    // mult with Req: no issue
    issue("mult_req", HILO_MULT, 32'd3, 32'd3, 1'b1, 1'b0);
    chk("mult_req_busy", {31'd0, bus.Busy}, 32'd0);
    chk_hilo("mult_req", 32'd1, 32'd2);

    // multu with Req pulse in flight; stale mfhi while busy
    issue("multu", HILO_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    tick();
    bus.Req = 1'b1;
    tick();
    bus.Req = 1'b0;
    chk("multu_busy_mid", {31'd0, bus.Busy}, 32'd1);
    bus.HILO_type = HILO_MFHI;
    #1;
    chk("multu_stale_hi", bus.HILO_out, 32'd1);
    bus.HILO_type = HILO_NONE;
    run_busy("multu_tail", 3);
    chk_hilo("multu", 32'd1, 32'hFFFF_FFFE);

    // reset during cycle 3 of a div aborts it
    issue("rdiv", HILO_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
    tick();
    tick();
    chk("rdiv_busy", {31'd0, bus.Busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rdiv_rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk_hilo("rdiv_rst", 32'd0, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rdiv_after_busy", {31'd0, bus.Busy}, 32'd0);
    chk_hilo("rdiv_after", 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
